// File: rtl/mem_responder_rv_pkg.sv
// Memory map, access-size encodings and store lane-alignment helpers shared by
// the memory responder, its console FIFO and anything that talks to it.
package mem_responder_rv_pkg;

    localparam int MMIO_BIT = 31;

    typedef enum logic [1:0] {
        REG_CONSOLE_TX = 2'd0,
        REG_STATUS     = 2'd1,
        REG_CYCLE      = 2'd2,
        REG_RESERVED   = 2'd3
    } mmio_reg_e;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    // Strobe lanes pushed past lane 3 fall off the top; misaligned accesses are not trapped.
    function automatic logic [3:0] align_strb(input logic [3:0] strb, input logic [1:0] lane);
        return strb << lane;
    endfunction

    function automatic logic [31:0] align_data(input logic [31:0] data, input logic [1:0] lane);
        return data << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/mem_responder_rv_if.sv
// Core-to-memory bus: one combinational read port, one byte-strobed write port
// and the console byte stream with its overflow flag.
interface mem_responder_rv_if;

    logic [31:0] iwReadAddr;
    logic [31:0] owReadData;
    logic [31:0] iwWriteAddr;
    logic [31:0] iwWriteData;
    logic [3:0]  iwWstrb;
    logic [7:0]  owConsoleData;
    logic        owConsoleValid;
    logic        iwConsoleReady;
    logic        owOverflow;

    modport slave (
        input  iwReadAddr, iwWriteAddr, iwWriteData, iwWstrb, iwConsoleReady,
        output owReadData, owConsoleData, owConsoleValid, owOverflow
    );

    modport master (
        output iwReadAddr, iwWriteAddr, iwWriteData, iwWstrb, iwConsoleReady,
        input  owReadData, owConsoleData, owConsoleValid, owOverflow
    );

endinterface

// File: rtl/mem_responder_rv_console_fifo.sv
// Console transmit FIFO: byte-wide, no fall-through, push accepted when full only
// if a pop happens in the same cycle.
module mem_responder_rv_console_fifo #(
    parameter int  FIFO_DEPTH = 8,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign count_o = count_q;
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage arrays are not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_responder_rv.sv
// Memory-side responder for the RV core: word RAM plus an MMIO block holding the
// console FIFO, a status register and a free-running cycle counter.
module mem_responder_rv
    import mem_responder_rv_pkg::*;
#(
    parameter int    RAM_WORDS  = 4096,
    parameter string RAM_INIT   = "",
    parameter int    FIFO_DEPTH = 8
) (
    input  logic              iwClk,
    input  logic              iwnRst,
    mem_responder_rv_if.slave bus
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] ram_q [RAM_WORDS];

    // The core sends sub-word stores right-justified; move them onto their byte lanes.
    logic          wr_en;
    logic [1:0]    wr_lane;
    logic [3:0]    eff_strb;
    logic [31:0]   eff_data;
    logic          wr_mmio;
    mmio_reg_e     wr_reg;
    logic [AW-1:0] wr_idx;
    logic          ram_we;

    assign wr_en    = (bus.iwWstrb != STRB_NONE);
    assign wr_lane  = bus.iwWriteAddr[1:0];
    assign eff_strb = align_strb(bus.iwWstrb, wr_lane);
    assign eff_data = align_data(bus.iwWriteData, wr_lane);
    assign wr_mmio  = bus.iwWriteAddr[MMIO_BIT];
    assign wr_reg   = mmio_reg_e'(bus.iwWriteAddr[3:2]);
    assign wr_idx   = bus.iwWriteAddr[AW+1:2];
    assign ram_we   = wr_en && !wr_mmio;

    always_ff @(posedge iwClk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_strb[b]) ram_q[wr_idx][8*b +: 8] <= eff_data[8*b +: 8];
            end
        end
    end

    logic          con_push, con_pop;
    logic          con_full, con_empty;
    logic [7:0]    con_head;
    logic [CW-1:0] con_count;

    assign con_push = wr_en && wr_mmio && (wr_reg == REG_CONSOLE_TX) && eff_strb[0];
    assign con_pop  = !con_empty && bus.iwConsoleReady;

    mem_responder_rv_console_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk     (iwClk),
        .rst_n   (iwnRst),
        .push_i  (con_push),
        .data_i  (eff_data[7:0]),
        .pop_i   (con_pop),
        .head_o  (con_head),
        .full_o  (con_full),
        .empty_o (con_empty),
        .count_o (con_count)
    );

    logic        overflow_q, overflow_d;
    logic        ovf_set, ovf_clr;
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;

    assign ovf_set = con_push && con_full && !con_pop;
    assign ovf_clr = wr_en && wr_mmio && (wr_reg == REG_STATUS) && eff_strb[0]
                     && eff_data[STATUS_OVF_BIT];
    assign cycle_d = cycle_q + 32'd1;

    // A dropped push in the same cycle as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (ovf_set) overflow_d = 1'b1;
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end

    logic          rd_mmio;
    mmio_reg_e     rd_reg;
    logic [AW-1:0] rd_idx;
    logic [31:0]   status_word;
    logic [31:0]   rd_data;

    assign rd_mmio = bus.iwReadAddr[MMIO_BIT];
    assign rd_reg  = mmio_reg_e'(bus.iwReadAddr[3:2]);
    assign rd_idx  = bus.iwReadAddr[AW+1:2];

    always_comb begin
        status_word                           = '0;
        status_word[STATUS_COUNT_LSB +: 4]    = 4'(con_count);
        status_word[STATUS_OVF_BIT]           = overflow_q;
        status_word[STATUS_EMPTY_BIT]         = con_empty;
        status_word[STATUS_FULL_BIT]          = con_full;
    end

    always_comb begin
        rd_data = '0;
        if (!rd_mmio) begin
            rd_data = ram_q[rd_idx];
        end else begin
            case (rd_reg)
                REG_STATUS: rd_data = status_word;
                REG_CYCLE:  rd_data = cycle_q;
                default:    rd_data = '0;
            endcase
        end
    end

    assign bus.owReadData     = rd_data;
    assign bus.owConsoleData  = con_head;
    assign bus.owConsoleValid = !con_empty;
    assign bus.owOverflow     = overflow_q;

    // Address bits above the RAM index alias, and reads are always word-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.iwReadAddr[30:AW+2], bus.iwReadAddr[1:0],
                                bus.iwWriteAddr[30:AW+2]};

endmodule

// File: tb/tb_mem_responder_rv.sv
// Scoreboard bench for mem_responder_rv: RAM lane alignment, console FIFO,
// status/overflow, cycle counter and asynchronous reset.
module tb_mem_responder_rv;
    import mem_responder_rv_pkg::*;

    localparam int          DEPTH       = 8;
    localparam logic [31:0] CON_ADDR    = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0008;
    localparam logic [31:0] RSVD_ADDR   = 32'h8000_000C;

    logic clk = 1'b0;
    logic rst_n;

    mem_responder_rv_if bus ();

    mem_responder_rv #(
        .RAM_WORDS  (4096),
        .RAM_INIT   (""),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .iwClk  (clk),
        .iwnRst (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  con_model [$];
    logic        model_ovf;
    logic [31:0] cyc_base;
    int unsigned cyc_mark;
    logic [31:0] c1, c2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[7:4] = 4'(con_model.size());
        s[2]   = model_ovf;
        s[1]   = (con_model.size() == 0);
        s[0]   = (con_model.size() == DEPTH);
        return s;
    endfunction

    function automatic logic [31:0] exp_cycle();
        return cyc_base + 32'(edge_cnt - cyc_mark);
    endfunction

    task automatic write_bus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        bus.iwWriteAddr = addr;
        bus.iwWriteData = data;
        bus.iwWstrb     = strb;
        @(posedge clk);
        #1;
        bus.iwWstrb = STRB_NONE;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        bus.iwReadAddr = addr;
        exp_q.push_back(exp);
        #1;
        check(tag, bus.owReadData, exp_q.pop_front());
    endtask

    task automatic status_check(input string tag);
        @(negedge clk);
        bus.iwReadAddr = STATUS_ADDR;
        exp_q.push_back(exp_status());
        #1;
        check(tag, bus.owReadData, exp_q.pop_front());
    endtask

    task automatic cycle_check(input string tag);
        @(negedge clk);
        bus.iwReadAddr = CYCLE_ADDR;
        exp_q.push_back(exp_cycle());
        #1;
        check(tag, bus.owReadData, exp_q.pop_front());
    endtask

    task automatic console_write(input logic [7:0] b);
        if (con_model.size() < DEPTH) con_model.push_back(b);
        else model_ovf = 1'b1;
        write_bus(CON_ADDR, {24'h0, b}, STRB_BYTE);
    endtask

    task automatic pop_cycle(input string tag);
        logic [7:0] exp_b;
        @(negedge clk);
        bus.iwConsoleReady = 1'b1;
        exp_b = 8'h00;
        if (con_model.size() != 0) exp_b = con_model.pop_front();
        #1;
        check(tag, 32'(bus.owConsoleData), 32'(exp_b));
        @(posedge clk);
        #1;
        bus.iwConsoleReady = 1'b0;
    endtask

    task automatic push_pop_full(input logic [7:0] b);
        logic [7:0] exp_b;
        @(negedge clk);
        bus.iwWriteAddr    = CON_ADDR;
        bus.iwWriteData    = {24'h0, b};
        bus.iwWstrb        = STRB_BYTE;
        bus.iwConsoleReady = 1'b1;
        exp_b = con_model.pop_front();
        con_model.push_back(b);
        #1;
        check("full_push_pop_head", 32'(bus.owConsoleData), 32'(exp_b));
        @(posedge clk);
        #1;
        bus.iwWstrb        = STRB_NONE;
        bus.iwConsoleReady = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        bus.iwReadAddr     = '0;
        bus.iwWriteAddr    = '0;
        bus.iwWriteData    = '0;
        bus.iwWstrb        = STRB_NONE;
        bus.iwConsoleReady = 1'b0;
        model_ovf          = 1'b0;
        cyc_base           = '0;
        cyc_mark           = 0;

        // Reset state
        #12;
        check("rst_valid", 32'(bus.owConsoleValid), 32'd0);
        check("rst_data", 32'(bus.owConsoleData), 32'd0);
        check("rst_overflow", 32'(bus.owOverflow), 32'd0);
        read_check("rst_cycle", CYCLE_ADDR, 32'd0);
        read_check("rst_status", STATUS_ADDR, 32'h0000_0002);
        @(negedge clk);
        rst_n    = 1'b1;
        cyc_base = '0;
        cyc_mark = edge_cnt;
        cycle_check("cycle_after_rst");

        // RAM and store alignment
        write_bus(32'h10, 32'h1122_3344, STRB_WORD);
        write_bus(32'h12, 32'h0000_00AB, STRB_BYTE);
        read_check("word_then_byte", 32'h10, 32'h11AB_3344);
        write_bus(32'h20, 32'h0, STRB_WORD);
        write_bus(32'h22, 32'h0000_BEEF, STRB_HALF);
        read_check("half_lane2", 32'h20, 32'hBEEF_0000);
        write_bus(32'h40, 32'h1234_5678, STRB_WORD);
        write_bus(32'h43, 32'h0000_CDEF, STRB_HALF);
        read_check("half_lane3_trunc", 32'h40, 32'hEF34_5678);
        write_bus(32'h50, 32'hFFFF_FFFF, STRB_WORD);
        write_bus(32'h51, 32'h0000_00A5, STRB_BYTE);
        read_check("byte_lane1", 32'h50, 32'hFFFF_A5FF);
        read_check("alias_read", 32'h4010, 32'h11AB_3344);
        write_bus(32'h4060, 32'hCAFE_F00D, STRB_WORD);
        read_check("alias_write", 32'h60, 32'hCAFE_F00D);
        read_check("reserved_read", RSVD_ADDR, 32'd0);
        read_check("console_tx_read", CON_ADDR, 32'd0);

        // Console ordering and handshake
        console_write(8'h48);
        console_write(8'h69);
        check("con_valid", 32'(bus.owConsoleValid), 32'd1);
        check("con_head_first", 32'(bus.owConsoleData), 32'(con_model[0]));
        status_check("status_count2");
        pop_cycle("pop_H");
        check("con_head_second", 32'(bus.owConsoleData), 32'(con_model[0]));
        status_check("status_count1");
        pop_cycle("pop_i");
        check("con_empty_valid", 32'(bus.owConsoleValid), 32'd0);
        check("con_empty_data", 32'(bus.owConsoleData), 32'd0);
        write_bus(CON_ADDR | 32'h1, 32'h0000_0055, STRB_BYTE);
        status_check("console_lane1_ignored");
        pop_cycle("pop_while_empty");
        status_check("status_after_empty_pop");

        // Overflow
        for (int i = 0; i < DEPTH + 1; i++) console_write(8'(8'h30 + i));
        check("overflow_set", 32'(bus.owOverflow), 32'd1);
        status_check("status_full_ovf");
        read_check("status_literal_85", STATUS_ADDR, 32'h0000_0085);
        write_bus(STATUS_ADDR, 32'h0000_0004, STRB_BYTE);
        model_ovf = 1'b0;
        check("overflow_cleared", 32'(bus.owOverflow), 32'd0);
        push_pop_full(8'h7A);
        status_check("status_full_after_push_pop");
        check("overflow_stays_clear", 32'(bus.owOverflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_cycle("drain");
        check("drained_valid", 32'(bus.owConsoleValid), 32'd0);

        // Cycle counter
        @(negedge clk);
        bus.iwReadAddr = CYCLE_ADDR;
        #1 c1 = bus.owReadData;
        repeat (5) @(negedge clk);
        #1 c2 = bus.owReadData;
        check("cycle_delta", c2 - c1, 32'd5);
        write_bus(CYCLE_ADDR, 32'h0, STRB_WORD);
        cycle_check("cycle_write_ignored");
        write_bus(RSVD_ADDR, 32'hFFFF_FFFF, STRB_WORD);
        status_check("reserved_write_ignored");
        @(negedge clk);
        force dut.cycle_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.cycle_d;
        cyc_base = 32'hFFFF_FFFF;
        cyc_mark = edge_cnt;
        cycle_check("cycle_forced_max");
        cycle_check("cycle_wrap");

        // Asynchronous reset with a non-empty FIFO
        console_write(8'h41);
        console_write(8'h42);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.owConsoleValid), 32'd0);
        check("midrst_data", 32'(bus.owConsoleData), 32'd0);
        con_model.delete();
        model_ovf = 1'b0;
        read_check("midrst_cycle", CYCLE_ADDR, 32'd0);
        read_check("midrst_ram_kept", 32'h10, 32'h11AB_3344);
        @(negedge clk);
        rst_n    = 1'b1;
        cyc_base = '0;
        cyc_mark = edge_cnt;
        status_check("status_after_midrst");
        cycle_check("cycle_after_midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
